// File: rtl/rf_scoreboard.sv
// Parametrised register file with hardwired x0 and a per-register busy scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining RF_SCOREBOARD_BYPASS_EN.
module rf_scoreboard #(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    parameter  int NRD   = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      rbusy,
    input  logic                we,
    input  logic [AW-1:0]       wa,
    input  logic [XLEN-1:0]     wd,
    input  logic                rsv,
    input  logic [AW-1:0]       rsv_a,
    input  logic                flush,
    output logic [AW:0]         nbusy
);

    logic [XLEN-1:0]  mem [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic [AW:0]      cnt_nxt;
    logic             wr_ok;
    logic             rsv_ok;

    assign wr_ok  = we && (wa != '0);
    assign rsv_ok = rsv && (rsv_a != '0);

    // Ordering matters: flush, then write clears, then reserve sets, so a
    // same-cycle reservation always wins over both flush and writeback.
    always_comb begin
        busy_nxt = flush ? '0 : busy;
        if (wr_ok)
            busy_nxt[wa] = 1'b0;
        if (rsv_ok)
            busy_nxt[rsv_a] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < NREGS; i++)
            cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[i]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                mem[i] <= '0;
            busy  <= '0;
            nbusy <= '0;
        end else begin
            if (wr_ok)
                mem[wa] <= wd;
            busy  <= busy_nxt;
            nbusy <= cnt_nxt;
        end
    end

    always_comb begin
        logic [AW-1:0] a;
        rd    = '0;
        rbusy = '0;
        for (int k = 0; k < NRD; k++) begin
            a = ra[k*AW +: AW];
            if (a != '0) begin
                rd[k*XLEN +: XLEN] = mem[a];
                rbusy[k]           = busy[a];
`ifdef RF_SCOREBOARD_BYPASS_EN
                if (wr_ok && (wa == a)) begin
                    rd[k*XLEN +: XLEN] = wd;
                    rbusy[k]           = rsv && (rsv_a == wa);
                end
`endif
            end
        end
    end

endmodule

// File: doc/rf_scoreboard.md
# rf_scoreboard

Parametrised integer register file for the single-cycle RISC-V core. It generalises the fixed 32×32, two-read-port bank to configurable width, depth and read-port count, and adds asynchronous reset, optional write-to-read bypass, and a per-register busy scoreboard. The scoreboard lets multi-cycle producers (load unit, future multiplier) reserve a destination so that readers can stall. It sits between decode (read addresses and reservations) and writeback (write port).

## Interface
- `XLEN`, 32, data width in bits.
- `NREGS`, 32, number of architectural registers; power of two, ≥2.
- `NRD`, 2, number of read ports (1..4).
- `AW`, $clog2(NREGS), address width (derived; do not override).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ra` in NRD*AW: read addresses; port k at bits [k*AW +: AW].
- `rd` out NRD*XLEN: read data; port k at bits [k*XLEN +: XLEN].
- `rbusy` out NRD: port k's register has a pending reservation.
- `we` in 1: write enable.
- `wa` in AW: write address.
- `wd` in XLEN: write data.
- `rsv` in 1: reserve request, marks `rsv_a` busy.
- `rsv_a` in AW: register to reserve.
- `flush` in 1: clears all busy bits (pipeline squash).
- `nbusy` out $clog2(NREGS)+1: count of busy registers.

## Operation
- Storage: NREGS×XLEN flops plus NREGS busy bits.
- Register 0 is hardwired zero. Writes and reservations to address 0 are ignored. Reads of address 0 return 0 with `rbusy`=0.
- Write: on a rising edge with `we`=1 and `wa`≠0, `mem[wa]` ← `wd` and `busy[wa]` ← 0.
- Reserve: on a rising edge with `rsv`=1 and `rsv_a`≠0, `busy[rsv_a]` ← 1.
- Simultaneous write and reserve:
  - Same address: the data is written and busy ends at 1, because the new reservation supersedes the old one.
  - Different addresses: both take effect.
- Flush: all busy bits ← 0. A same-cycle reserve is still applied after the flush. A same-cycle write is still applied.
- Reads are combinational and port-independent. Any number of ports may read the same address.
- `nbusy` is the registered population count of the busy bits, updated on the same edge as the bits.
- Reserving an already-busy register is legal: it stays busy and `nbusy` is unchanged.
- A write to a non-busy register is legal: it updates data and `nbusy` is unchanged.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert by the system):
  - all registers = 0 and all busy = 0, so `rd` = 0, `rbusy` = 0 and `nbusy` = 0 while `rst_n` = 0.
- Reset during an outstanding reservation clears it. The producer's later write still lands normally.
- Write latency: data is visible on `rd` the cycle after the write edge (the bypass configuration below changes this).
- Reserve latency: `rbusy` asserts the cycle after the reserve edge. There is no same-cycle reserve bypass.
- Read path: purely combinational from `ra` and state to `rd` and `rbusy`. There is no read enable.

## Configuration
- Macro `RF_SCOREBOARD_BYPASS_EN`.
- Defined, for each port k with `we`=1, `wa`≠0 and `wa`=`ra[k]`:
  - `rd[k]` = `wd` (write-first) in the same cycle;
  - `rbusy[k]` = 0 in the same cycle, unless `rsv`=1 and `rsv_a`=`wa`.
  - This removes the one-cycle writeback-to-decode hazard.
- Undefined: reads return the stored value only (read-before-write) and `rbusy` reflects the stored busy bits only.

## Test plan
- Reset: drive `rst_n`=0 mid-run after writing 0xDEADBEEF to x5 and reserving x7. Required: immediately `rd`=0 on all ports, `rbusy`=0, `nbusy`=0.
- Write/read and x0:
  - write 0x12345678 to x3, then read x3 on both ports next cycle; required: 0x12345678 on both ports.
  - write 0xFFFFFFFF to x0; required: reads of x0 return 0.
- Scoreboard:
  - reserve x4 then x9; required: `nbusy`=2 and reading x4 gives `rbusy`=1.
  - write x4=0xA5; required: next cycle `rbusy`=0, `rd`=0xA5, `nbusy`=1.
- Simultaneous events:
  - same cycle: write x6=0x11, reserve x6, and `flush` with x9 still busy; required: `mem[6]`=0x11, busy[6]=1, busy[9]=0, `nbusy`=1.
- Bypass: same cycle write x8=0x55 with `ra[0]`=x8 and x8 busy.
  - With `RF_SCOREBOARD_BYPASS_EN`: `rd[0]`=0x55 and `rbusy[0]`=0 in that cycle.
  - Without: old value and `rbusy[0]`=1 in that cycle; 0x55 and `rbusy[0]`=0 the next cycle.
- Parametrisation: run with XLEN=64, NREGS=16, NRD=3. Required: all of the above pass with three ports reading x0, x15 and x15 concurrently.
